emulador_sensor_ultrassonico: RTL and testbench
===============================================

Name: emulador_sensor_ultrassonico

Overview:
Synthesizable responder for the HC-SR04 trigger/echo protocol. It accepts a trigger pulse from a distance-measuring front end, waits a fixed burst delay, then drives echo high for a time proportional to a programmed distance. The distance is given in 3-digit BCD centimetres, matching the display format. It is used in bench and loopback on-board tests so the measurer can run without the physical sensor.

Parameters:
TRIG_MIN_CYCLES, 500, minimum trigger high time accepted (10 us at 50 MHz)
DELAY_CYCLES, 25000, gap between trigger fall and echo rise (500 us)
CYCLES_PER_CM, 2941, echo-high cycles per centimetre (58.82 us/cm at 50 MHz)
MAX_CM, 400, distance clamp in cm
HOLDOFF_CYCLES, 50000, dead time after echo fall during which triggers are ignored

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
trigger  in  1  trigger from the measurer, already synchronous to clock
distancia  in  12  BCD distance in cm: [11:8] hundreds, [7:4] tens, [3:0] units
echo  out  1  emulated echo pulse
pronto  out  1  one-cycle pulse on the cycle echo falls
db_estado  out  4  current FSM state code, for debug

Behaviour:
- Reset values: echo=0, pronto=0, db_estado=0. All counters clear and the latched distance is 0. Reset asserted mid-pulse drops echo asynchronously.
- All outputs are registered.
- FSM states and codes:
  - inicial (0): leaves after 1 cycle to aguarda.
  - aguarda (1): moves to mede_trigger when trigger=1; the trigger counter is loaded with 1.
  - mede_trigger (2): increments the trigger counter while trigger=1, saturating at TRIG_MIN_CYCLES. When trigger=0:
    - if count >= TRIG_MIN_CYCLES: latch the clamped distance, go to atraso.
    - otherwise: go back to aguarda (runt pulse ignored, no echo).
    - A trigger held high indefinitely stays in this state and is accepted on its falling edge.
  - atraso (3): counts DELAY_CYCLES, then goes to echo_alto.
  - echo_alto (4): echo=1. Nested counters: a cycle counter wraps at CYCLES_PER_CM-1, and each wrap increments a cm counter. Leaves when the cm counter reaches the latched cm value. Echo is high for exactly cm*CYCLES_PER_CM cycles. No multiplier is used.
  - descanso (5): echo=0. pronto=1 on the first cycle only. Counts HOLDOFF_CYCLES, then goes to aguarda.
- Trigger activity in atraso, echo_alto and descanso is ignored.
- Distance conversion, combinational, evaluated at the latch point:
  - cm = H*100 + T*10 + U.
  - Any BCD digit >9 is treated as 9.
  - cm > MAX_CM is clamped to MAX_CM.
  - cm = 0 is forced to 1, so echo is always at least one cm long.
  - A distancia change after the latch has no effect on the pulse in progress.
- Counter widths are derived with $clog2 from the parameters. Counters never wrap past their terminal value.
- Latency: echo rises DELAY_CYCLES+1 cycles after the cycle trigger is first sampled 0 in mede_trigger.

Decomposition:
- Shared package holds:
  - state codes for inicial..descanso (4-bit, equal to the db_estado values),
  - default timing constants,
  - the BCD digit-saturate function.
- One sub-module, conversor_bcd_cm: combinational BCD to binary conversion with digit saturation, MAX_CM clamp and zero-to-one forcing. 12-bit input, 10-bit output.
- The FSM and counters stay in the top module.

Test Plan:
Bench overrides: TRIG_MIN_CYCLES=5, DELAY_CYCLES=20, CYCLES_PER_CM=10, MAX_CM=400, HOLDOFF_CYCLES=30.
1. distancia=12'h025, trigger high 6 cycles -> echo rises 21 cycles after trigger fall, stays high 250 cycles, pronto pulses once at the fall, db_estado sequence 1,2,3,4,5,1.
2. Trigger high 3 cycles -> no echo, db_estado returns to 1, then a 5-cycle trigger with distancia=12'h001 -> echo high 10 cycles.
3. distancia=12'h999 -> echo high 4000 cycles (clamp to 400). distancia=12'h000 -> 10 cycles. distancia=12'h0AF -> treated as 99 cm, 990 cycles.
4. Second trigger pulse issued during echo_alto and during descanso -> ignored, a single echo only. A trigger 31 cycles after pronto -> accepted.
5. distancia changed from 12'h010 to 12'h300 while echo is high -> echo width stays 100 cycles.
6. Reset asserted mid-echo -> echo=0 immediately (asynchronous), db_estado=0. After release, a normal trigger gives a correct pulse.

Source files
------------

// File: rtl/emulador_sensor_ultrassonico_pkg.sv
// Shared definitions for the ultrasonic sensor emulator: FSM state codes,
// default timing constants and the BCD digit-saturation helper.
package emulador_sensor_ultrassonico_pkg;

    // State codes double as the db_estado debug value.
    typedef enum logic [3:0] {
        ST_INICIAL      = 4'd0,
        ST_AGUARDA      = 4'd1,
        ST_MEDE_TRIGGER = 4'd2,
        ST_ATRASO       = 4'd3,
        ST_ECHO_ALTO    = 4'd4,
        ST_DESCANSO     = 4'd5
    } estado_t;

    // Default timing for a 50 MHz clock.
    localparam int DEF_TRIG_MIN_CYCLES = 500;
    localparam int DEF_DELAY_CYCLES    = 25000;
    localparam int DEF_CYCLES_PER_CM   = 2941;
    localparam int DEF_MAX_CM          = 400;
    localparam int DEF_HOLDOFF_CYCLES  = 50000;

    // Out-of-range BCD digits (A..F) are read as 9.
    function automatic logic [3:0] bcd_sat(input logic [3:0] digito);
        if (digito > 4'd9) begin
            return 4'd9;
        end else begin
            return digito;
        end
    endfunction

endpackage

// File: rtl/emulador_sensor_ultrassonico_conversor_bcd_cm.sv
// BCD centimetre value to binary, with digit saturation, upper clamp and
// a minimum of 1 cm so the emulated echo never has zero width.
module conversor_bcd_cm
    import emulador_sensor_ultrassonico_pkg::*;
#(
    parameter int MAX_CM = DEF_MAX_CM
) (
    input  logic [11:0] bcd,
    output logic [9:0]  cm
);

    localparam logic [9:0] MAX_CM_W = 10'(MAX_CM);

    logic [3:0] centena_s;
    logic [3:0] dezena_s;
    logic [3:0] unidade_s;
    logic [9:0] soma_s;

    // Weighted digit sum followed by clamp and zero-to-one forcing.
    always_comb begin
        centena_s = bcd_sat(bcd[11:8]);
        dezena_s  = bcd_sat(bcd[7:4]);
        unidade_s = bcd_sat(bcd[3:0]);
        soma_s    = ({6'd0, centena_s} * 10'd100)
                  + ({6'd0, dezena_s} * 10'd10)
                  + {6'd0, unidade_s};
        if (soma_s > MAX_CM_W) begin
            cm = MAX_CM_W;
        end else if (soma_s == 10'd0) begin
            cm = 10'd1;
        end else begin
            cm = soma_s;
        end
    end

endmodule

// File: rtl/emulador_sensor_ultrassonico.sv
// HC-SR04 trigger/echo responder: validates the trigger width, waits a fixed
// burst delay, then holds echo high for cm * CYCLES_PER_CM cycles.
module emulador_sensor_ultrassonico
    import emulador_sensor_ultrassonico_pkg::*;
#(
    parameter int TRIG_MIN_CYCLES = DEF_TRIG_MIN_CYCLES,
    parameter int DELAY_CYCLES    = DEF_DELAY_CYCLES,
    parameter int CYCLES_PER_CM   = DEF_CYCLES_PER_CM,
    parameter int MAX_CM          = DEF_MAX_CM,
    parameter int HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        trigger,
    input  logic [11:0] distancia,
    output logic        echo,
    output logic        pronto,
    output logic [3:0]  db_estado
);

    localparam int TRIG_W  = $clog2(TRIG_MIN_CYCLES + 1);
    localparam int DELAY_W = $clog2(DELAY_CYCLES + 1);
    localparam int CYC_W   = $clog2(CYCLES_PER_CM + 1);
    localparam int CM_W    = $clog2(MAX_CM + 1);
    localparam int HOLD_W  = $clog2(HOLDOFF_CYCLES + 1);

    localparam logic [TRIG_W-1:0]  TRIG_MIN_W = TRIG_W'(TRIG_MIN_CYCLES);
    localparam logic [DELAY_W-1:0] DELAY_W_C  = DELAY_W'(DELAY_CYCLES);
    localparam logic [CYC_W-1:0]   CYC_LAST   = CYC_W'(CYCLES_PER_CM - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLDOFF_CYCLES - 1);

    estado_t             state_r;
    estado_t             next_s;
    logic [TRIG_W-1:0]   trig_cnt_r;
    logic [DELAY_W-1:0]  delay_cnt_r;
    logic [CYC_W-1:0]    cyc_cnt_r;
    logic [CM_W-1:0]     cm_cnt_r;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic [9:0]          cm_lat_r;
    logic [9:0]          cm_s;
    logic                echo_s;
    logic                pronto_s;
    logic                echo_r;
    logic                pronto_r;

    conversor_bcd_cm #(
        .MAX_CM (MAX_CM)
    ) u_conversor (
        .bcd (distancia),
        .cm  (cm_s)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_INICIAL;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state decode from the current state, trigger and counters.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_INICIAL: begin
                next_s = ST_AGUARDA;
            end
            ST_AGUARDA: begin
                if (trigger) begin
                    next_s = ST_MEDE_TRIGGER;
                end else begin
                    next_s = ST_AGUARDA;
                end
            end
            ST_MEDE_TRIGGER: begin
                if (trigger) begin
                    next_s = ST_MEDE_TRIGGER;
                end else if (trig_cnt_r >= TRIG_MIN_W) begin
                    next_s = ST_ATRASO;
                end else begin
                    next_s = ST_AGUARDA;
                end
            end
            ST_ATRASO: begin
                if (delay_cnt_r == DELAY_W_C) begin
                    next_s = ST_ECHO_ALTO;
                end else begin
                    next_s = ST_ATRASO;
                end
            end
            ST_ECHO_ALTO: begin
                if ((cyc_cnt_r == CYC_LAST) && (10'(cm_cnt_r) == (cm_lat_r - 10'd1))) begin
                    next_s = ST_DESCANSO;
                end else begin
                    next_s = ST_ECHO_ALTO;
                end
            end
            ST_DESCANSO: begin
                if (hold_cnt_r == HOLD_LAST) begin
                    next_s = ST_AGUARDA;
                end else begin
                    next_s = ST_DESCANSO;
                end
            end
            default: begin
                next_s = ST_INICIAL;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up with state_r.
    always_comb begin
        echo_s   = (next_s == ST_ECHO_ALTO);
        pronto_s = (next_s == ST_DESCANSO) && (state_r != ST_DESCANSO);
    end

    // Output registers; reset drops echo immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            echo_r   <= 1'b0;
            pronto_r <= 1'b0;
        end else begin
            echo_r   <= echo_s;
            pronto_r <= pronto_s;
        end
    end

    // Per-state counters; each phase clears the counter of the phase that follows it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            trig_cnt_r  <= '0;
            delay_cnt_r <= '0;
            cyc_cnt_r   <= '0;
            cm_cnt_r    <= '0;
            hold_cnt_r  <= '0;
            cm_lat_r    <= 10'd0;
        end else begin
            case (state_r)
                ST_AGUARDA: begin
                    trig_cnt_r <= trigger ? TRIG_W'(1) : TRIG_W'(0);
                end
                ST_MEDE_TRIGGER: begin
                    delay_cnt_r <= '0;
                    if (trigger) begin
                        if (trig_cnt_r < TRIG_MIN_W) begin
                            trig_cnt_r <= trig_cnt_r + TRIG_W'(1);
                        end
                    end else if (trig_cnt_r >= TRIG_MIN_W) begin
                        cm_lat_r <= cm_s;
                    end
                end
                ST_ATRASO: begin
                    cyc_cnt_r <= '0;
                    cm_cnt_r  <= '0;
                    if (delay_cnt_r != DELAY_W_C) begin
                        delay_cnt_r <= delay_cnt_r + DELAY_W'(1);
                    end
                end
                ST_ECHO_ALTO: begin
                    hold_cnt_r <= '0;
                    if (cyc_cnt_r == CYC_LAST) begin
                        cyc_cnt_r <= '0;
                        if (10'(cm_cnt_r) != cm_lat_r) begin
                            cm_cnt_r <= cm_cnt_r + CM_W'(1);
                        end
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + CYC_W'(1);
                    end
                end
                ST_DESCANSO: begin
                    if (hold_cnt_r != HOLD_LAST) begin
                        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                    end
                end
                default: begin
                    trig_cnt_r <= trig_cnt_r;
                end
            endcase
        end
    end

    assign echo      = echo_r;
    assign pronto    = pronto_r;
    assign db_estado = state_r;

endmodule

// File: tb/tb_emulador_sensor_ultrassonico.sv
// Directed self-checking bench for emulador_sensor_ultrassonico with short timing parameters.
module tb_emulador_sensor_ultrassonico;

    logic        clock = 1'b0;
    logic        reset;
    logic        trigger;
    logic [11:0] distancia;
    logic        echo;
    logic        pronto;
    logic [3:0]  db_estado;

    int n_checks = 0;
    int n_fail   = 0;

    bit rec_en = 1'b0;
    int seq[$];
    int pronto_total = 0;

    emulador_sensor_ultrassonico #(
        .TRIG_MIN_CYCLES (5),
        .DELAY_CYCLES    (20),
        .CYCLES_PER_CM   (10),
        .MAX_CM          (400),
        .HOLDOFF_CYCLES  (30)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .trigger   (trigger),
        .distancia (distancia),
        .echo      (echo),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    // Records pronto pulses and db_estado transitions away from the active edge.
    always @(negedge clock) begin
        if (pronto === 1'b1) pronto_total = pronto_total + 1;
        if (rec_en) begin
            if (seq.size() == 0 || seq[seq.size()-1] != int'(db_estado))
                seq.push_back(int'(db_estado));
        end
    end

    // Drives trigger high for n sampling edges; entered and left #1 after a posedge.
    task automatic pulse_trigger(input int n);
        trigger = 1'b1;
        repeat (n) @(posedge clock);
        #1;
        trigger = 1'b0;
    endtask

    // Called right after trigger falls: latency (edges from the first low sample)
    // and echo width, with optional distancia change and trigger pulse mid-echo.
    task automatic measure_echo(input int chg_at, input logic [11:0] nd,
                                input int trig_on, input int trig_off,
                                output int lat, output int width, output logic pf);
        @(posedge clock);
        #1;
        lat = 0;
        while (echo !== 1'b1 && lat < 200) begin
            @(posedge clock);
            #1;
            lat++;
        end
        width = 0;
        while (echo === 1'b1 && width < 5000) begin
            width++;
            if (width == chg_at) distancia = nd;
            if (width == trig_on) trigger = 1'b1;
            if (width == trig_off) trigger = 1'b0;
            @(posedge clock);
            #1;
        end
        pf = pronto;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        trigger = 1'b0;
        distancia = 12'h000;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (echo !== 1'b0) begin n_fail++; $display("FAIL reset_echo: got %b want 0", echo); end
        n_checks++;
        if (pronto !== 1'b0) begin n_fail++; $display("FAIL reset_pronto: got %b want 0", pronto); end
        n_checks++;
        if (db_estado !== 4'd0) begin n_fail++; $display("FAIL reset_estado: got %0d want 0", db_estado); end
        reset = 1'b0;
        @(posedge clock);
        #1;
        n_checks++;
        if (db_estado !== 4'd1) begin n_fail++; $display("FAIL reset_to_aguarda: got %0d want 1", db_estado); end
    endtask

    task automatic test_echo_basico();
        int lat, wid, p0;
        logic pf;
        bit ok;
        int exp_seq[6] = '{1, 2, 3, 4, 5, 1};
        distancia = 12'h025;
        p0 = pronto_total;
        rec_en = 1'b1;
        pulse_trigger(6);
        measure_echo(0, 12'h000, 0, 0, lat, wid, pf);
        repeat (31) @(posedge clock);
        #1;
        rec_en = 1'b0;
        n_checks++;
        if (lat !== 21) begin n_fail++; $display("FAIL basic_latency: got %0d want 21", lat); end
        n_checks++;
        if (wid !== 250) begin n_fail++; $display("FAIL basic_width: got %0d want 250", wid); end
        n_checks++;
        if (pf !== 1'b1) begin n_fail++; $display("FAIL basic_pronto_at_fall: got %b want 1", pf); end
        n_checks++;
        if (pronto_total - p0 !== 1) begin n_fail++; $display("FAIL basic_pronto_count: got %0d want 1", pronto_total - p0); end
        ok = (seq.size() == 6);
        if (ok) begin
            for (int i = 0; i < 6; i++) if (seq[i] != exp_seq[i]) ok = 1'b0;
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_state_seq: got %p want 1,2,3,4,5,1", seq); end
    endtask

    task automatic test_runt();
        int lat, wid;
        logic pf;
        bit saw_echo;
        distancia = 12'h025;
        pulse_trigger(3);
        saw_echo = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (echo === 1'b1) saw_echo = 1'b1;
        end
        n_checks++;
        if (saw_echo) begin n_fail++; $display("FAIL runt_no_echo: got echo=1 want no echo"); end
        n_checks++;
        if (db_estado !== 4'd1) begin n_fail++; $display("FAIL runt_estado: got %0d want 1", db_estado); end
        distancia = 12'h001;
        pulse_trigger(5);
        measure_echo(0, 12'h000, 0, 0, lat, wid, pf);
        n_checks++;
        if (lat !== 21) begin n_fail++; $display("FAIL min_trig_latency: got %0d want 21", lat); end
        n_checks++;
        if (wid !== 10) begin n_fail++; $display("FAIL min_trig_width: got %0d want 10", wid); end
        repeat (31) @(posedge clock);
        #1;
    endtask

    task automatic test_clamp();
        logic [11:0] dist_tab[3] = '{12'h999, 12'h000, 12'h0AF};
        int          wid_tab[3]  = '{4000, 10, 990};
        int lat, wid;
        logic pf;
        for (int i = 0; i < 3; i++) begin
            distancia = dist_tab[i];
            pulse_trigger(6);
            measure_echo(0, 12'h000, 0, 0, lat, wid, pf);
            n_checks++;
            if (wid !== wid_tab[i]) begin
                n_fail++;
                $display("FAIL clamp_width[%h]: got %0d want %0d", dist_tab[i], wid, wid_tab[i]);
            end
            repeat (31) @(posedge clock);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        int lat, wid, p0;
        logic pf;
        bit bad_echo, bad_state;
        distancia = 12'h012;
        p0 = pronto_total;
        pulse_trigger(6);
        measure_echo(0, 12'h000, 10, 16, lat, wid, pf);
        n_checks++;
        if (wid !== 120) begin n_fail++; $display("FAIL ignore_echo_width: got %0d want 120", wid); end
        bad_echo = 1'b0;
        bad_state = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 5) trigger = 1'b1;
            if (k == 11) trigger = 1'b0;
            @(posedge clock);
            #1;
            if (echo !== 1'b0) bad_echo = 1'b1;
            if (k < 30 && db_estado !== 4'd5) bad_state = 1'b1;
        end
        n_checks++;
        if (bad_echo) begin n_fail++; $display("FAIL ignore_descanso_echo: got echo=1 want 0"); end
        n_checks++;
        if (bad_state) begin n_fail++; $display("FAIL ignore_descanso_state: got left state 5 want 5"); end
        n_checks++;
        if (db_estado !== 4'd1) begin n_fail++; $display("FAIL holdoff_end_estado: got %0d want 1", db_estado); end
        n_checks++;
        if (pronto_total - p0 !== 1) begin n_fail++; $display("FAIL ignore_single_pronto: got %0d want 1", pronto_total - p0); end
        pulse_trigger(6);
        measure_echo(0, 12'h000, 0, 0, lat, wid, pf);
        n_checks++;
        if (lat !== 21) begin n_fail++; $display("FAIL after_holdoff_latency: got %0d want 21", lat); end
        n_checks++;
        if (wid !== 120) begin n_fail++; $display("FAIL after_holdoff_width: got %0d want 120", wid); end
        repeat (31) @(posedge clock);
        #1;
    endtask

    task automatic test_distancia_estavel();
        int lat, wid;
        logic pf;
        distancia = 12'h010;
        pulse_trigger(6);
        measure_echo(20, 12'h300, 0, 0, lat, wid, pf);
        n_checks++;
        if (wid !== 100) begin n_fail++; $display("FAIL latched_width: got %0d want 100", wid); end
        repeat (31) @(posedge clock);
        #1;
    endtask

    task automatic test_reset_meio();
        int lat, wid, guard;
        logic pf;
        distancia = 12'h050;
        pulse_trigger(6);
        guard = 0;
        while (echo !== 1'b1 && guard < 200) begin
            @(posedge clock);
            #1;
            guard++;
        end
        n_checks++;
        if (echo !== 1'b1) begin n_fail++; $display("FAIL midreset_echo_start: got %b want 1", echo); end
        repeat (50) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if (echo !== 1'b0) begin n_fail++; $display("FAIL midreset_echo: got %b want 0", echo); end
        n_checks++;
        if (db_estado !== 4'd0) begin n_fail++; $display("FAIL midreset_estado: got %0d want 0", db_estado); end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        distancia = 12'h003;
        pulse_trigger(6);
        measure_echo(0, 12'h000, 0, 0, lat, wid, pf);
        n_checks++;
        if (lat !== 21) begin n_fail++; $display("FAIL post_reset_latency: got %0d want 21", lat); end
        n_checks++;
        if (wid !== 30) begin n_fail++; $display("FAIL post_reset_width: got %0d want 30", wid); end
    endtask

    initial begin
        test_reset();
        test_echo_basico();
        test_runt();
        test_clamp();
        test_back_to_back();
        test_distancia_estavel();
        test_reset_meio();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
